als_sample_scheduler: RTL and testbench



---
 rtl/als_sample_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_als_sample_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/als_sample_scheduler.sv
// als_sample_scheduler
// Sequences ambient-light-sensor conversions: periodic or on-demand start,
// trigger/done/oe handshake with a timeout abort, sample capture and a
// block average over 2^AVG_LOG2 samples. Every output is a flop.

module als_sample_scheduler #(
    parameter int PERIOD_CYCLES  = 100_000,
    parameter int TIMEOUT_CYCLES = 16_000,
    parameter int AVG_LOG2       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        req,
    input  logic        clear_err,
    input  logic        als_done,
    input  logic [31:0] als_data,
    output logic        als_trigger,
    output logic        als_oe,
    output logic [7:0]  sample,
    output logic        sample_valid,
    output logic [7:0]  avg,
    output logic        avg_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2
    } state_e;

    state_e             state_r;
    state_e             state_s;
    logic [PER_W-1:0]   per_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_s;
    logic               pending_r;
    logic               done_q_r;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_s;
    logic [ACC_W-1:0]   sum_s;
    logic [CNT_W-1:0]   blk_cnt_r;
    logic [CNT_W-1:0]   blk_cnt_s;

    logic               als_trigger_r;
    logic               als_trigger_s;
    logic               als_oe_r;
    logic               als_oe_s;
    logic [7:0]         sample_r;
    logic [7:0]         sample_s;
    logic               sample_valid_r;
    logic               sample_valid_s;
    logic [7:0]         avg_r;
    logic [7:0]         avg_s;
    logic               avg_valid_r;
    logic               avg_valid_s;
    logic               busy_r;
    logic               timeout_err_r;
    logic               err_set_s;

    logic               tick_s;
    logic               start_s;
    logic               done_rise_s;
    logic               unused_s;

    // Only the low byte of the sensor bus carries the light sample.
    assign unused_s    = ^als_data[31:8];

    assign tick_s      = enable & (per_cnt_r == PER_LAST);
    assign start_s     = req | tick_s | pending_r;
    assign done_rise_s = als_done & ~done_q_r;
    assign sum_s       = acc_r + ACC_W'(als_data[7:0]);

    assign als_trigger  = als_trigger_r;
    assign als_oe       = als_oe_r;
    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign avg          = avg_r;
    assign avg_valid    = avg_valid_r;
    assign busy         = busy_r;
    assign timeout_err  = timeout_err_r;

    // Period counter: runs only while enabled, wraps after the tick cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_r <= '0;
        end else if (!enable) begin
            per_cnt_r <= '0;
        end else if (per_cnt_r == PER_LAST) begin
            per_cnt_r <= '0;
        end else begin
            per_cnt_r <= per_cnt_r + PER_W'(1);
        end
    end

    // Done edge history and the single merged pending-start slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q_r  <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            done_q_r <= als_done;
            if (state_r != ST_IDLE) begin
                pending_r <= pending_r | req | tick_s;
            end else begin
                // IDLE either accepts the start now or there was nothing pending.
                pending_r <= 1'b0;
            end
        end
    end

    // Next-state and next-output logic for the conversion sequencer.
    always_comb begin
        state_s        = state_r;
        tmo_cnt_s      = tmo_cnt_r;
        als_trigger_s  = als_trigger_r;
        als_oe_s       = 1'b0;
        sample_s       = sample_r;
        sample_valid_s = 1'b0;
        avg_s          = avg_r;
        avg_valid_s    = 1'b0;
        acc_s          = acc_r;
        blk_cnt_s      = blk_cnt_r;
        err_set_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s       = ST_WAIT;
                    als_trigger_s = 1'b1;
                    tmo_cnt_s     = '0;
                end else begin
                    als_trigger_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (done_rise_s) begin
                    state_s       = ST_READ;
                    als_trigger_s = 1'b0;
                    als_oe_s      = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    // Abort: no sample, block count untouched.
                    state_s       = ST_IDLE;
                    als_trigger_s = 1'b0;
                    err_set_s     = 1'b1;
                end else begin
                    tmo_cnt_s     = tmo_cnt_r + TMO_W'(1);
                end
            end
            ST_READ: begin
                state_s        = ST_IDLE;
                als_trigger_s  = 1'b0;
                sample_s       = als_data[7:0];
                sample_valid_s = 1'b1;
                if (blk_cnt_r == BLK_LAST) begin
                    avg_s       = 8'(sum_s >> AVG_LOG2);
                    avg_valid_s = 1'b1;
                    acc_s       = '0;
                    blk_cnt_s   = '0;
                end else begin
                    acc_s       = sum_s;
                    blk_cnt_s   = blk_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s       = ST_IDLE;
                als_trigger_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            tmo_cnt_r      <= '0;
            acc_r          <= '0;
            blk_cnt_r      <= '0;
            als_trigger_r  <= 1'b0;
            als_oe_r       <= 1'b0;
            sample_r       <= 8'h00;
            sample_valid_r <= 1'b0;
            avg_r          <= 8'h00;
            avg_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
            timeout_err_r  <= 1'b0;
        end else begin
            state_r        <= state_s;
            tmo_cnt_r      <= tmo_cnt_s;
            acc_r          <= acc_s;
            blk_cnt_r      <= blk_cnt_s;
            als_trigger_r  <= als_trigger_s;
            als_oe_r       <= als_oe_s;
            sample_r       <= sample_s;
            sample_valid_r <= sample_valid_s;
            avg_r          <= avg_s;
            avg_valid_r    <= avg_valid_s;
            busy_r         <= (state_s != ST_IDLE);
            // A new abort outranks a simultaneous clear.
            timeout_err_r  <= err_set_s | (timeout_err_r & ~clear_err);
        end
    end

endmodule

// File: tb/tb_als_sample_scheduler.sv
// Self-checking bench for als_sample_scheduler with a behavioural sensor model.

module tb_als_sample_scheduler;

    localparam int PERIOD = 500;
    localparam int TMO    = 200;
    localparam int AL2    = 2;
    localparam int BLK    = 1 << AL2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        req;
    logic        clear_err;
    logic        als_done = 1'b0;
    logic [31:0] als_data = 32'h0;
    logic        als_trigger;
    logic        als_oe;
    logic [7:0]  sample;
    logic        sample_valid;
    logic [7:0]  avg;
    logic        avg_valid;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    // Sensor model controls (written by the test sequence only)
    bit       sensor_on   = 1'b0;
    bit       force_done  = 1'b0;
    int       sensor_delay = 10;
    bit [7:0] sensor_data = 8'h00;

    // Observation state (written by the negedge monitor only)
    int cyc       = 0;
    int sv_count  = 0;
    int trig_age  = 0;
    bit prev_trig = 1'b0;
    int trig_rise_q[$];

    als_sample_scheduler #(
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TMO),
        .AVG_LOG2      (AL2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .clear_err   (clear_err),
        .als_done    (als_done),
        .als_data    (als_data),
        .als_trigger (als_trigger),
        .als_oe      (als_oe),
        .sample      (sample),
        .sample_valid(sample_valid),
        .avg         (avg),
        .avg_valid   (avg_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Monitor plus sensor: raises done sensor_delay negedges after trigger rises.
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_trig <= als_trigger;
        if (als_trigger === 1'b1 && prev_trig !== 1'b1) trig_rise_q.push_back(cyc);
        if (sample_valid === 1'b1) sv_count <= sv_count + 1;
        if (sensor_on) begin
            if (als_trigger === 1'b1) begin
                if (trig_age == sensor_delay) begin
                    als_done <= 1'b1;
                    als_data <= {24'($urandom()), sensor_data};
                end
                trig_age <= trig_age + 1;
            end else begin
                trig_age <= 0;
                als_done <= 1'b0;
            end
        end else begin
            trig_age <= 0;
            als_done <= force_done;
            als_data <= {24'($urandom()), sensor_data};
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step(1);
        req = 1'b0;
    endtask

    // Stimulus helper: one on-demand conversion, returns what was observed.
    task automatic do_conv(input bit [7:0] d, input int dly, output bit ok,
                           output bit av, output bit [7:0] s, output bit [7:0] a);
        int t;
        sensor_on    = 1'b1;
        sensor_data  = d;
        sensor_delay = dly;
        pulse_req();
        t = 0;
        while (sample_valid !== 1'b1 && t < dly + 50) begin
            step(1);
            t++;
        end
        ok = (sample_valid === 1'b1);
        av = avg_valid;
        s  = sample;
        a  = avg;
        step(1);
    endtask

    task automatic test_reset();
        int base;
        rst = 1'b1; req = 1'b1; enable = 1'b0; clear_err = 1'b0;
        force_done = 1'b1; sensor_on = 1'b0;
        step(3);
        total++; if (als_trigger !== 1'b0) begin bad++; $display("FAIL reset_trigger: got %b want 0", als_trigger); end
        total++; if (als_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", als_oe); end
        total++; if (sample !== 8'h00) begin bad++; $display("FAIL reset_sample: got %h want 00", sample); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_sample_valid: got %b want 0", sample_valid); end
        total++; if (avg !== 8'h00) begin bad++; $display("FAIL reset_avg: got %h want 00", avg); end
        total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL reset_avg_valid: got %b want 0", avg_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", timeout_err); end
        rst = 1'b0; req = 1'b0; force_done = 1'b0;
        base = trig_rise_q.size();
        step(1000);
        total++; if (trig_rise_q.size() != base) begin bad++; $display("FAIL idle_no_trigger: got %0d rises want 0", trig_rise_q.size() - base); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        int t, trig_hi, oe_n, t_oe, base_sv;
        sensor_on = 1'b1; sensor_delay = 100; sensor_data = 8'hA5;
        base_sv = sv_count;
        pulse_req();
        total++; if (als_trigger !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_start: got trig=%b busy=%b want 1 1", als_trigger, busy); end
        t = 0; trig_hi = 1; oe_n = 0; t_oe = -1;
        while (sample_valid !== 1'b1 && t < 500) begin
            step(1);
            t++;
            if (als_trigger === 1'b1) trig_hi++;
            if (als_oe === 1'b1) begin oe_n++; t_oe = t; end
        end
        total++; if (t >= 500) begin bad++; $display("FAIL single_timeout: got no sample_valid within %0d cycles", t); end
        total++; if (sample !== 8'hA5) begin bad++; $display("FAIL single_sample: got %h want a5", sample); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %b want 0", busy); end
        total++; if (oe_n != 1 || t_oe != t - 1) begin bad++; $display("FAIL single_oe: got %0d cycles at %0d want 1 at %0d", oe_n, t_oe, t - 1); end
        total++; if (trig_hi != sensor_delay + 1) begin bad++; $display("FAIL single_trig_len: got %0d want %0d", trig_hi, sensor_delay + 1); end
        total++; if (t != sensor_delay + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", t, sensor_delay + 2); end
        step(1);
        total++; if (sample_valid !== 1'b0 || sv_count - base_sv != 1) begin bad++; $display("FAIL single_pulse: got sv=%b count=%0d want 0 1", sample_valid, sv_count - base_sv); end
    endtask

    task automatic test_periodic();
        int base, base_sv, t;
        sensor_on = 1'b1; sensor_delay = 50; sensor_data = 8'($urandom_range(0, 255));
        base = trig_rise_q.size(); base_sv = sv_count;
        enable = 1'b1;
        step(1600);
        total++; if (trig_rise_q.size() - base != 3) begin bad++; $display("FAIL periodic_count: got %0d want 3", trig_rise_q.size() - base); end
        for (int i = base + 1; i < trig_rise_q.size(); i++) begin
            total++;
            if (trig_rise_q[i] - trig_rise_q[i-1] != PERIOD) begin bad++; $display("FAIL periodic_spacing: got %0d want %0d", trig_rise_q[i] - trig_rise_q[i-1], PERIOD); end
        end
        total++; if (sv_count - base_sv != 3 || sample !== sensor_data) begin bad++; $display("FAIL periodic_samples: got %0d/%h want 3/%h", sv_count - base_sv, sample, sensor_data); end
        t = 0;
        while (als_trigger !== 1'b1 && t < 600) begin step(1); t++; end
        step(10);
        enable = 1'b0;
        t = 0;
        while (sample_valid !== 1'b1 && t < 200) begin step(1); t++; end
        total++; if (sample_valid !== 1'b1 || sample !== sensor_data) begin bad++; $display("FAIL disable_inflight: got sv=%b %h want 1 %h", sample_valid, sample, sensor_data); end
        base = trig_rise_q.size();
        step(1200);
        total++; if (trig_rise_q.size() != base) begin bad++; $display("FAIL disable_stops: got %0d rises want 0", trig_rise_q.size() - base); end
    endtask

    task automatic test_merge();
        int base, base_sv, t, lo;
        sensor_on = 1'b1; sensor_delay = 60; sensor_data = 8'($urandom_range(0, 255));
        base = trig_rise_q.size(); base_sv = sv_count;
        enable = 1'b1;
        step(460);
        pulse_req();
        step(10);
        pulse_req();
        t = 0;
        while (busy !== 1'b0 && t < 300) begin step(1); t++; end
        lo = 0;
        while (busy === 1'b0 && lo < 10) begin lo++; step(1); end
        total++; if (lo != 1) begin bad++; $display("FAIL merge_gap: got %0d idle cycles want 1", lo); end
        enable = 1'b0;
        t = 0;
        while (busy !== 1'b0 && t < 300) begin step(1); t++; end
        step(700);
        total++; if (trig_rise_q.size() - base != 2) begin bad++; $display("FAIL merge_conversions: got %0d want 2", trig_rise_q.size() - base); end
        total++; if (sv_count - base_sv != 2) begin bad++; $display("FAIL merge_samples: got %0d want 2", sv_count - base_sv); end
    endtask

    task automatic test_stale();
        int oe_n, t;
        sensor_on = 1'b0; force_done = 1'b1; sensor_data = 8'h3C;
        step(2);
        pulse_req();
        oe_n = 0;
        for (int i = 0; i < 20; i++) begin step(1); if (als_oe === 1'b1) oe_n++; end
        total++; if (oe_n != 0 || als_trigger !== 1'b1) begin bad++; $display("FAIL stale_done: got oe=%0d trig=%b want 0 1", oe_n, als_trigger); end
        force_done = 1'b0; step(2); force_done = 1'b1;
        t = 0;
        while (sample_valid !== 1'b1 && t < 10) begin step(1); t++; end
        total++; if (sample_valid !== 1'b1 || sample !== 8'h3C) begin bad++; $display("FAIL stale_then_rise: got sv=%b %h want 1 3c", sample_valid, sample); end
        force_done = 1'b0;
        step(3);
    endtask

    task automatic test_timeout();
        int hi, base_sv;
        sensor_on = 1'b0; force_done = 1'b0;
        base_sv = sv_count;
        pulse_req();
        hi = 0;
        while (als_trigger === 1'b1 && hi < 1000) begin hi++; step(1); end
        total++; if (hi != TMO) begin bad++; $display("FAIL timeout_len: got %0d want %0d", hi, TMO); end
        total++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_err_set: got err=%b busy=%b want 1 0", timeout_err, busy); end
        total++; if (sv_count != base_sv) begin bad++; $display("FAIL timeout_no_sample: got %0d want 0", sv_count - base_sv); end
        clear_err = 1'b1; step(1); clear_err = 1'b0;
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL clear_err: got %b want 0", timeout_err); end
        pulse_req();
        step(TMO - 1);
        total++; if (timeout_err !== 1'b0 || als_trigger !== 1'b1) begin bad++; $display("FAIL pre_collision: got err=%b trig=%b want 0 1", timeout_err, als_trigger); end
        clear_err = 1'b1; step(1); clear_err = 1'b0;
        total++; if (timeout_err !== 1'b1 || als_trigger !== 1'b0) begin bad++; $display("FAIL set_beats_clear: got err=%b trig=%b want 1 0", timeout_err, als_trigger); end
        clear_err = 1'b1; step(1); clear_err = 1'b0;
    endtask

    task automatic test_average();
        bit ok, av;
        bit [7:0] s, a, d;
        bit [7:0] fixed_q[$];
        int sum, t;
        do_conv(8'hFF, 5, ok, av, s, a);
        do_conv(8'hFF, 5, ok, av, s, a);
        sensor_delay = 40;
        pulse_req();
        step(10);
        rst = 1'b1; step(1); rst = 1'b0;
        total++; if (als_trigger !== 1'b0 || busy !== 1'b0 || sample !== 8'h00) begin bad++; $display("FAIL rst_mid: got trig=%b busy=%b sample=%h want 0 0 00", als_trigger, busy, sample); end
        step(2);
        fixed_q = '{8'h10, 8'h20, 8'h30, 8'h41};
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                sensor_on = 1'b0; force_done = 1'b0;
                pulse_req();
                t = 0;
                while (busy !== 1'b0 && t < 400) begin step(1); t++; end
                clear_err = 1'b1; step(1); clear_err = 1'b0;
            end
            d = fixed_q[i];
            sum += d;
            do_conv(d, $urandom_range(3, 40), ok, av, s, a);
            total++; if (!ok || s !== d) begin bad++; $display("FAIL avg_fixed_sample%0d: got ok=%b %h want %h", i, ok, s, d); end
            total++; if (av !== (i == 3)) begin bad++; $display("FAIL avg_fixed_valid%0d: got %b want %b", i, av, (i == 3)); end
        end
        total++; if (a !== 8'h28 || a !== 8'(sum / BLK)) begin bad++; $display("FAIL avg_fixed_value: got %h want 28", a); end
        for (int blk = 0; blk < 3; blk++) begin
            sum = 0;
            for (int i = 0; i < BLK; i++) begin
                d = 8'($urandom_range(0, 255));
                sum += d;
                do_conv(d, $urandom_range(3, 40), ok, av, s, a);
                total++; if (!ok || s !== d) begin bad++; $display("FAIL avg_rand_sample: got ok=%b %h want %h", ok, s, d); end
                total++; if (av !== (i == BLK - 1)) begin bad++; $display("FAIL avg_rand_valid: got %b want %b", av, (i == BLK - 1)); end
                if (i == BLK - 1) begin
                    total++; if (a !== 8'(sum / BLK)) begin bad++; $display("FAIL avg_rand_value: got %h want %h", a, 8'(sum / BLK)); end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; req = 1'b0; clear_err = 1'b0;
        test_reset();
        test_single();
        test_periodic();
        test_merge();
        test_stale();
        test_timeout();
        test_average();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
